parking_slot_allocator: RTL and testbench

Sequential, parametrised successor to the combinational entry slot picker. It owns the occupancy register for NUM_SLOTS parking bays. On an entry request it allocates the lowest-indexed free bay and drives an entry gate for a fixed open time. It also accepts bay-release (exit) requests and reports occupancy count, full status and error pulses to the display/control layer.

---
 rtl/parking_slot_allocator_if.sv | 37 +++
 rtl/parking_slot_allocator.sv | 146 ++++++++++++++
 tb/tb_parking_slot_allocator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_allocator_if
// Description : Entry/exit request and status bundle of the parking slot
//               allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_slot_allocator_if #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int CNT_W     = 4
);
    logic                 entry_req;
    logic                 exit_req;
    logic [SLOT_W-1:0]    exit_slot;
    logic                 entry_grant;
    logic                 entry_deny;
    logic [SLOT_W-1:0]    park_number;
    logic                 gate_open;
    logic                 exit_err;
    logic [NUM_SLOTS-1:0] occupancy;
    logic [CNT_W-1:0]     free_count;
    logic                 full;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_grant, entry_deny, park_number, gate_open,
        input  exit_err, occupancy, free_count, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_grant, entry_deny, park_number, gate_open,
        output exit_err, occupancy, free_count, full
    );
endinterface
`default_nettype wire

// File: rtl/parking_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_allocator
// Description : Allocates the lowest free parking bay on entry, times the
//               entry gate, and services bay releases with error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_allocator #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_W      = 3,
    parameter int CNT_W       = 4,
    parameter int GATE_CYCLES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    parking_slot_allocator_if.slave    bus
);

    localparam int                   c_TMR_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0]   c_GATE_LOAD  = c_TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     c_ALL_FREE   = CNT_W'(NUM_SLOTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_TMR_W-1:0]     r_gate_cnt;
    logic [c_TMR_W-1:0]     w_gate_cnt_nxt;
    logic [NUM_SLOTS-1:0]   r_occ;
    logic [NUM_SLOTS-1:0]   w_occ_nxt;
    logic [CNT_W-1:0]       r_free;
    logic [CNT_W-1:0]       w_free_nxt;
    logic [SLOT_W-1:0]      r_park;
    logic [SLOT_W-1:0]      w_free_idx;
    logic                   r_grant;
    logic                   r_deny;
    logic                   r_exit_err;
    logic                   w_grant;
    logic                   w_deny;
    logic                   w_full;
    logic [NUM_SLOTS-1:0]   w_grant_mask;
    logic [NUM_SLOTS-1:0]   w_exit_mask;
    logic                   w_exit_ok;

    assign w_full = (r_free == '0);

    // Isolate the lowest clear bit of the registered occupancy.
    assign w_grant_mask = ~r_occ & (r_occ + NUM_SLOTS'(1));

    always_comb begin
        w_free_idx  = '0;
        w_exit_mask = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_idx = SLOT_W'(i);
            end
            w_exit_mask[i] = (SLOT_W'(i) == bus.exit_slot);
        end
    end

    // The mask only spans real bays, so an out-of-range index never hits.
    assign w_exit_ok = bus.exit_req && (|(r_occ & w_exit_mask));

    always_comb begin
        w_next_state   = r_state;
        w_gate_cnt_nxt = r_gate_cnt;
        w_grant        = 1'b0;
        w_deny         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.entry_req) begin
                    if (!w_full) begin
                        w_grant        = 1'b1;
                        w_next_state   = S_GATE;
                        w_gate_cnt_nxt = c_GATE_LOAD;
                    end else begin
                        w_deny = 1'b1;
                    end
                end
            end
            S_GATE: begin
                if (r_gate_cnt == '0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt - c_TMR_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_grant) begin
            w_occ_nxt = w_occ_nxt | w_grant_mask;
        end
        if (w_exit_ok) begin
            w_occ_nxt = w_occ_nxt & ~w_exit_mask;
        end
        case ({w_grant, w_exit_ok})
            2'b10:   w_free_nxt = r_free - CNT_W'(1);
            2'b01:   w_free_nxt = r_free + CNT_W'(1);
            default: w_free_nxt = r_free;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gate_cnt <= '0;
            r_occ      <= '0;
            r_free     <= c_ALL_FREE;
            r_park     <= '0;
            r_grant    <= 1'b0;
            r_deny     <= 1'b0;
            r_exit_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_gate_cnt <= w_gate_cnt_nxt;
            r_occ      <= w_occ_nxt;
            r_free     <= w_free_nxt;
            r_grant    <= w_grant;
            r_deny     <= w_deny;
            r_exit_err <= bus.exit_req && !w_exit_ok;
            if (w_grant) begin
                r_park <= w_free_idx;
            end
        end
    end

    assign bus.entry_grant = r_grant;
    assign bus.entry_deny  = r_deny;
    assign bus.park_number = r_park;
    assign bus.gate_open   = (r_state == S_GATE);
    assign bus.exit_err    = r_exit_err;
    assign bus.occupancy   = r_occ;
    assign bus.free_count  = r_free;
    assign bus.full        = w_full;

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_slot_allocator
// Description : Directed self-checking bench for parking_slot_allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_slot_allocator;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    parking_slot_allocator_if #(.NUM_SLOTS(8), .SLOT_W(3), .CNT_W(4)) bus8 ();
    parking_slot_allocator_if #(.NUM_SLOTS(6), .SLOT_W(3), .CNT_W(3)) bus6 ();

    parking_slot_allocator #(
        .NUM_SLOTS(8), .SLOT_W(3), .CNT_W(4), .GATE_CYCLES(4)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    parking_slot_allocator #(
        .NUM_SLOTS(6), .SLOT_W(3), .CNT_W(3), .GATE_CYCLES(4)
    ) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_cnt      = 0;
        bad_cnt        = 0;
        rst            = 1'b1;
        bus8.entry_req = 1'b0;
        bus8.exit_req  = 1'b0;
        bus8.exit_slot = '0;
        bus6.entry_req = 1'b0;
        bus6.exit_req  = 1'b0;
        bus6.exit_slot = '0;
        tick();
        tick();

        check_value("rst_occ",   bus8.occupancy,   8'h00);
        check_value("rst_free",  bus8.free_count,  4'd8);
        check_value("rst_full",  bus8.full,        1'b0);
        check_value("rst_park",  bus8.park_number, 3'd0);
        check_value("rst_grant", bus8.entry_grant, 1'b0);
        check_value("rst_deny",  bus8.entry_deny,  1'b0);
        check_value("rst_gate",  bus8.gate_open,   1'b0);
        check_value("rst_xerr",  bus8.exit_err,    1'b0);
        check_value("rst_free6", bus6.free_count,  3'd6);
        rst = 1'b0;

        // Out-of-range release on the 6-bay lot.
        bus6.exit_req  = 1'b1;
        bus6.exit_slot = 3'd7;
        tick();
        check_value("n6_xerr", bus6.exit_err,  1'b1);
        check_value("n6_occ",  bus6.occupancy, 6'h00);
        check_value("n6_free", bus6.free_count, 3'd6);
        bus6.exit_req = 1'b0;
        tick();
        check_value("n6_xerr_clr", bus6.exit_err, 1'b0);

        // Fill the lot with entry_req held: one grant every 5 cycles.
        bus8.entry_req = 1'b1;
        for (int car = 0; car < 8; car++) begin
            if (car == 0) begin
                tick();
            end
            check_value("fill_grant", bus8.entry_grant, 1'b1);
            check_value("fill_park",  bus8.park_number, car);
            check_value("fill_gate",  bus8.gate_open,   1'b1);
            check_value("fill_free",  bus8.free_count,  8 - car - 1);
            for (int c = 0; c < 3; c++) begin
                tick();
                check_value("fill_gate_hold", bus8.gate_open,   1'b1);
                check_value("fill_grant_low", bus8.entry_grant, 1'b0);
            end
            tick();
            check_value("fill_gate_closed", bus8.gate_open, 1'b0);
            tick();
        end
        // Ninth sample hits a full lot.
        check_value("full_deny",  bus8.entry_deny,  1'b1);
        check_value("full_grant", bus8.entry_grant, 1'b0);
        check_value("full_occ",   bus8.occupancy,   8'hFF);
        check_value("full_free",  bus8.free_count,  4'd0);
        check_value("full_flag",  bus8.full,        1'b1);
        bus8.entry_req = 1'b0;
        tick();
        check_value("full_deny_pulse", bus8.entry_deny, 1'b0);

        // Release bays 0,1,3,5,7 leaving 8'b01010100.
        bus8.exit_req = 1'b1;
        for (int s = 0; s < 8; s++) begin
            if (s == 0 || s == 1 || s == 3 || s == 5 || s == 7) begin
                bus8.exit_slot = 3'(s);
                tick();
                check_value("rel_xerr", bus8.exit_err, 1'b0);
            end
        end
        bus8.exit_req = 1'b0;
        check_value("pre_occ",  bus8.occupancy,  8'h54);
        check_value("pre_free", bus8.free_count, 4'd5);

        bus8.entry_req = 1'b1;
        tick();
        bus8.entry_req = 1'b0;
        check_value("pre_grant", bus8.entry_grant, 1'b1);
        check_value("pre_park",  bus8.park_number, 3'd0);
        check_value("pre_occ2",  bus8.occupancy,   8'h55);
        check_value("pre_free2", bus8.free_count,  4'd4);
        for (int c = 0; c < 4; c++) tick();
        check_value("pre_gate_closed", bus8.gate_open, 1'b0);

        // Releasing an already free bay.
        bus8.exit_req  = 1'b1;
        bus8.exit_slot = 3'd5;
        tick();
        bus8.exit_req = 1'b0;
        check_value("free_xerr", bus8.exit_err,   1'b1);
        check_value("free_occ",  bus8.occupancy,  8'h55);
        check_value("free_cnt",  bus8.free_count, 4'd4);
        tick();
        check_value("free_xerr_pulse", bus8.exit_err, 1'b0);
        check_value("free_park_hold",  bus8.park_number, 3'd0);

        // Refill the odd bays, then exit bay 3 alongside a denied entry.
        bus8.entry_req = 1'b1;
        for (int car = 0; car < 4; car++) begin
            tick();
            check_value("odd_grant", bus8.entry_grant, 1'b1);
            check_value("odd_park",  bus8.park_number, 2 * car + 1);
            for (int c = 0; c < 4; c++) tick();
        end
        check_value("odd_full", bus8.full, 1'b1);
        bus8.exit_req  = 1'b1;
        bus8.exit_slot = 3'd3;
        tick();
        bus8.exit_req = 1'b0;
        check_value("sim_deny",  bus8.entry_deny,  1'b1);
        check_value("sim_grant", bus8.entry_grant, 1'b0);
        check_value("sim_occ",   bus8.occupancy,   8'hF7);
        check_value("sim_free",  bus8.free_count,  4'd1);
        check_value("sim_xerr",  bus8.exit_err,    1'b0);
        tick();
        bus8.entry_req = 1'b0;
        check_value("sim_regrant", bus8.entry_grant, 1'b1);
        check_value("sim_park",    bus8.park_number, 3'd3);
        check_value("sim_occ2",    bus8.occupancy,   8'hFF);

        // Asynchronous reset in the second gate cycle.
        tick();
        check_value("gate2_open", bus8.gate_open, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_value("arst_gate", bus8.gate_open,  1'b0);
        check_value("arst_occ",  bus8.occupancy,  8'h00);
        check_value("arst_free", bus8.free_count, 4'd8);
        check_value("arst_full", bus8.full,       1'b0);
        rst = 1'b0;
        bus8.entry_req = 1'b1;
        tick();
        bus8.entry_req = 1'b0;
        check_value("post_grant", bus8.entry_grant, 1'b1);
        check_value("post_park",  bus8.park_number, 3'd0);
        check_value("post_occ",   bus8.occupancy,   8'h01);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
